shift_feed_ctrl: RTL and testbench

Upstream feeder for the 8-bit shift-register delay line. It buffers bytes arriving on a valid/ready input in a small FIFO and drives the delay line's data_in and shift_enable. Four source modes are available: FIFO with stall, FIFO with fill-byte substitution, PRBS-8 test pattern and a counting pattern. It also keeps a running count of bytes emitted into the delay line.

---
 rtl/shift_feed_ctrl_if.sv | 26 ++
 rtl/shift_feed_ctrl.sv | 112 +++++++++++
 tb/tb_shift_feed_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/shift_feed_ctrl_if.sv
// Byte feed bundle between the upstream source, the feeder and the delay line.
interface shift_feed_ctrl_if #(
   parameter int LVL_W = 3
);
   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       mode;
   logic             run;
   logic [7:0]       shift_data;
   logic             shift_enable;
   logic [LVL_W-1:0] level;
   logic [15:0]      bytes_sent;

   // Driver side: upstream source plus mode/run control; observes feeder outputs.
   modport master (
      output in_data, in_valid, mode, run,
      input  in_ready, shift_data, shift_enable, level, bytes_sent
   );

   // Feeder side.
   modport slave (
      input  in_data, in_valid, mode, run,
      output in_ready, shift_data, shift_enable, level, bytes_sent
   );
endinterface

// File: rtl/shift_feed_ctrl.sv
// Delay-line feeder: small byte FIFO plus four source modes
// (fifo-stall, fifo-fill, PRBS-8, counting) and an emitted-byte counter.
module shift_feed_ctrl #(
   parameter int         DEPTH     = 4,
   parameter logic [7:0] FILL_BYTE = 8'h00,
   parameter int         LVL_W     = $clog2(DEPTH + 1)
) (
   input logic          clk,
   input logic          rst,
   shift_feed_ctrl_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      M_STALL = 2'b00,
      M_FILL  = 2'b01,
      M_PRBS  = 2'b10,
      M_COUNT = 2'b11
   } mode_e;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [LVL_W-1:0] level_q;
   logic [7:0]       lfsr, cnt;
   logic [7:0]       sd_q;
   logic             se_q;
   logic [15:0]      sent_q;

   logic             push, pop, emit, lfsr_step, cnt_step, empty;
   logic [7:0]       emit_data;
   logic [7:0]       lfsr_nxt;

   // Readiness comes from the pre-edge level only: no pop bypass when full.
   assign bus.in_ready = (level_q != LVL_W'(DEPTH));
   assign push         = bus.in_valid & bus.in_ready;
   assign empty        = (level_q == '0);
   assign lfsr_nxt     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

   assign bus.shift_data   = sd_q;
   assign bus.shift_enable = se_q;
   assign bus.level        = level_q;
   assign bus.bytes_sent   = sent_q;

   // Source select: decide pop/emit and the emitted byte from pre-edge state.
   always_comb begin
      pop       = 1'b0;
      emit      = 1'b0;
      emit_data = sd_q;
      lfsr_step = 1'b0;
      cnt_step  = 1'b0;
      if (bus.run) begin
         case (mode_e'(bus.mode))
            M_STALL: begin
               if (!empty) begin
                  pop       = 1'b1;
                  emit      = 1'b1;
                  emit_data = mem[rd_ptr];
               end
            end
            M_FILL: begin
               emit      = 1'b1;
               pop       = !empty;
               emit_data = empty ? FILL_BYTE : mem[rd_ptr];
            end
            M_PRBS: begin
               emit      = 1'b1;
               emit_data = lfsr;
               lfsr_step = 1'b1;
            end
            default: begin
               emit      = 1'b1;
               emit_data = cnt;
               cnt_step  = 1'b1;
            end
         endcase
      end
   end

   // FIFO storage; no reset needed since pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.in_data;
   end

   // Pointers, level, pattern generators and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         lfsr    <= 8'h01;
         cnt     <= 8'h00;
         sd_q    <= 8'h00;
         se_q    <= 1'b0;
         sent_q  <= 16'h0000;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
         if (lfsr_step) lfsr <= lfsr_nxt;
         if (cnt_step)  cnt  <= cnt + 8'h01;
         se_q <= emit;
         if (emit) begin
            sd_q   <= emit_data;
            sent_q <= sent_q + 16'h0001;
         end
      end
   end
endmodule

// File: tb/tb_shift_feed_ctrl.sv
// Randomized + directed bench for shift_feed_ctrl against a queue-based model.
module tb_shift_feed_ctrl;
   localparam int         DEPTH = 4;
   localparam int         LVL_W = $clog2(DEPTH + 1);
   localparam logic [7:0] FILL  = 8'h00;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   shift_feed_ctrl_if #(.LVL_W(LVL_W)) bus ();

   shift_feed_ctrl #(.DEPTH(DEPTH), .FILL_BYTE(FILL), .LVL_W(LVL_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_bad = 0;

   // model state
   logic [7:0]  q[$];
   logic [7:0]  m_lfsr = 8'h01;
   logic [7:0]  m_cnt  = 8'h00;
   logic [7:0]  m_sd   = 8'h00;
   logic        m_se   = 1'b0;
   logic [15:0] m_bs   = 16'h0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model by the rules, compare after the edge.
   task automatic step(input logic r, input logic v, input logic [7:0] d,
                       input logic [1:0] m, input logic ru);
      logic acc;
      logic se_n;
      rst          = r;
      bus.in_valid = v;
      bus.in_data  = d;
      bus.mode     = m;
      bus.run      = ru;
      acc = v && (q.size() < DEPTH);
      if (r) begin
         q.delete();
         m_lfsr = 8'h01; m_cnt = 8'h00; m_sd = 8'h00; m_se = 1'b0; m_bs = 16'h0;
      end else begin
         se_n = 1'b0;
         if (ru) begin
            case (m)
               2'd0: if (q.size() > 0) begin m_sd = q.pop_front(); se_n = 1'b1; end
               2'd1: begin
                  se_n = 1'b1;
                  if (q.size() > 0) m_sd = q.pop_front(); else m_sd = FILL;
               end
               2'd2: begin
                  se_n = 1'b1; m_sd = m_lfsr;
                  m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
               end
               default: begin se_n = 1'b1; m_sd = m_cnt; m_cnt = m_cnt + 8'h01; end
            endcase
         end
         if (acc) q.push_back(d);
         m_se = se_n;
         if (se_n) m_bs = m_bs + 16'h1;
      end
      @(posedge clk);
      #1;
      chk("shift_data",   bus.shift_data,   m_sd);
      chk("shift_enable", bus.shift_enable, m_se);
      chk("level",        bus.level,        q.size());
      chk("bytes_sent",   bus.bytes_sent,   m_bs);
      chk("in_ready",     bus.in_ready,     q.size() < DEPTH);
   endtask

   logic [7:0] prbs_first [5];
   logic [7:0] prbs_obs;
   int         zero_seen;

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.mode     = 2'd0;
      bus.run      = 1'b0;

      // reset state
      step(1, 0, 8'h00, 2'd0, 0);
      step(1, 0, 8'h00, 2'd0, 0);
      chk("rst_level", bus.level, 0);
      chk("rst_sd",    bus.shift_data, 8'h00);

      // single byte through mode 00
      step(0, 1, 8'hA5, 2'd0, 1);
      step(0, 0, 8'h00, 2'd0, 1);
      chk("a5_data", bus.shift_data, 8'hA5);
      chk("a5_se",   bus.shift_enable, 1'b1);
      step(0, 0, 8'h00, 2'd0, 1);
      chk("a5_one_strobe", bus.shift_enable, 1'b0);

      // fill while stopped, fifth byte refused
      step(0, 1, 8'h11, 2'd0, 0);
      step(0, 1, 8'h22, 2'd0, 0);
      step(0, 1, 8'h33, 2'd0, 0);
      step(0, 1, 8'h44, 2'd0, 0);
      chk("full_ready", bus.in_ready, 1'b0);
      step(0, 1, 8'h55, 2'd0, 0);
      chk("full_level", bus.level, DEPTH);
      step(0, 0, 8'h00, 2'd0, 1); chk("drain0", bus.shift_data, 8'h11);
      step(0, 0, 8'h00, 2'd0, 1); chk("drain1", bus.shift_data, 8'h22);
      step(0, 0, 8'h00, 2'd0, 1); chk("drain2", bus.shift_data, 8'h33);
      step(0, 0, 8'h00, 2'd0, 1); chk("drain3", bus.shift_data, 8'h44);
      step(0, 0, 8'h00, 2'd0, 1); chk("drain_stop", bus.shift_enable, 1'b0);

      // fill mode: push into empty FIFO emits fill first
      step(0, 0, 8'h00, 2'd1, 1);
      step(0, 1, 8'h7E, 2'd1, 1); chk("fill_first", bus.shift_data, FILL);
      step(0, 0, 8'h00, 2'd1, 1); chk("fill_7e",    bus.shift_data, 8'h7E);
      step(0, 0, 8'h00, 2'd1, 1); chk("fill_again", bus.shift_data, FILL);

      // PRBS from reset
      step(1, 0, 8'h00, 2'd2, 0);
      prbs_first = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
      zero_seen = 0;
      for (int i = 0; i < 256; i++) begin
         step(0, 0, 8'h00, 2'd2, 1);
         prbs_obs = bus.shift_data;
         if (prbs_obs == 8'h00) zero_seen++;
         if (i < 5) chk("prbs_head", prbs_obs, prbs_first[i]);
      end
      chk("prbs_period", prbs_obs, 8'h01);
      chk("prbs_nozero", zero_seen, 0);

      // counting mode with a run gap
      step(1, 0, 8'h00, 2'd3, 0);
      for (int i = 0; i < 258; i++) begin
         step(0, 0, 8'h00, 2'd3, 1);
         if (i == 257) chk("cnt_wrap", bus.shift_data, 8'h01);
         if (i == 100) begin
            for (int k = 0; k < 3; k++) begin
               step(0, 0, 8'h00, 2'd3, 0);
               chk("cnt_gap_se", bus.shift_enable, 1'b0);
            end
         end
      end

      // reset mid-stream with level 3
      step(0, 1, 8'h01, 2'd0, 0);
      step(0, 1, 8'h02, 2'd0, 0);
      step(0, 1, 8'h03, 2'd0, 0);
      chk("pre_rst_level", bus.level, 3);
      step(1, 0, 8'h00, 2'd2, 1);
      chk("mid_rst_level", bus.level, 0);
      chk("mid_rst_bs",    bus.bytes_sent, 16'h0);
      step(0, 0, 8'h00, 2'd2, 1);
      chk("mid_rst_prbs",  bus.shift_data, 8'h01);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), 8'($urandom),
              2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
